// File: rtl/trax_pkg.sv
// Shared definitions for the Trax move parser: tile codes, move field layout,
// ASCII constants, parser state encoding and character-class helpers.
package trax_pkg;

  localparam int MOVE_W    = 22;
  localparam int FIELD_W   = 10;
  localparam int TILE_LSB  = 20;
  localparam int ROW_LSB   = 10;
  localparam int COL_LSB   = 0;

  localparam logic [1:0] TILE_PLUS   = 2'd0;
  localparam logic [1:0] TILE_SLASH  = 2'd1;
  localparam logic [1:0] TILE_BSLASH = 2'd2;

  localparam logic [7:0] ASC_AT     = 8'h40;
  localparam logic [7:0] ASC_Z      = 8'h5A;
  localparam logic [7:0] ASC_0      = 8'h30;
  localparam logic [7:0] ASC_9      = 8'h39;
  localparam logic [7:0] ASC_PLUS   = 8'h2B;
  localparam logic [7:0] ASC_SLASH  = 8'h2F;
  localparam logic [7:0] ASC_BSLASH = 8'h5C;
  localparam logic [7:0] ASC_SPACE  = 8'h20;
  localparam logic [7:0] ASC_CR     = 8'h0D;
  localparam logic [7:0] ASC_LF     = 8'h0A;

  typedef enum logic [1:0] {
    S_COL  = 2'd0,
    S_ROW0 = 2'd1,
    S_ROW  = 2'd2,
    S_TILE = 2'd3
  } parse_state_e;

  function automatic logic is_col(input logic [7:0] c);
    return (c >= ASC_AT) && (c <= ASC_Z);
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASC_0) && (c <= ASC_9);
  endfunction

  function automatic logic is_ws(input logic [7:0] c);
    return (c == ASC_SPACE) || (c == ASC_CR) || (c == ASC_LF);
  endfunction

  function automatic logic is_tile(input logic [7:0] c);
    return (c == ASC_PLUS) || (c == ASC_SLASH) || (c == ASC_BSLASH);
  endfunction

  function automatic logic [1:0] tile_code(input logic [7:0] c);
    logic [1:0] t;
    t = TILE_PLUS;
    if (c == ASC_SLASH)  t = TILE_SLASH;
    if (c == ASC_BSLASH) t = TILE_BSLASH;
    return t;
  endfunction

endpackage

// File: rtl/trax_move_parser.sv
// Byte-serial Trax move parser (<column><row><tile>) with a one-entry output holding register.
// Optional inter-byte idle timeout enabled by defining TRAX_PARSER_TIMEOUT_EN.
module trax_move_parser
  import trax_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [MOVE_W-1:0]   move_out,
  output logic                move_valid,
  input  logic                move_ready,
  output logic                parse_err
);

  parse_state_e       state;
  logic [FIELD_W-1:0] col_lat;
  logic [FIELD_W-1:0] row_acc;
  logic [1:0]         dig_cnt;
  logic               timed_out;

  logic [FIELD_W-1:0] digit_val;
  logic [FIELD_W-1:0] row_next;
  logic [FIELD_W-1:0] col_val;
  logic               out_blocked;

  // row_acc is at most 99 whenever a third digit is folded in, so x10 fits in 10 bits
  assign digit_val   = {6'd0, rx_data[3:0]};
  assign row_next    = {row_acc[6:0], 3'b000} + {row_acc[8:0], 1'b0} + digit_val;
  assign col_val     = {5'd0, rx_data[4:0]};
  assign out_blocked = move_valid && !move_ready;

`ifdef TRAX_PARSER_TIMEOUT_EN
  logic [23:0] idle_cnt;

  assign timed_out = (state != S_COL) && !rx_valid && ((idle_cnt + 24'd1) == TIMEOUT_CYCLES);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idle_cnt <= 24'd0;
    end else if (rx_valid || (state == S_COL) || timed_out) begin
      idle_cnt <= 24'd0;
    end else begin
      idle_cnt <= idle_cnt + 24'd1;
    end
  end
`else
  logic timeout_unused;
  assign timeout_unused = ^TIMEOUT_CYCLES;
  assign timed_out      = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_COL;
      col_lat    <= '0;
      row_acc    <= '0;
      dig_cnt    <= 2'd0;
      move_out   <= '0;
      move_valid <= 1'b0;
      parse_err  <= 1'b0;
    end else begin
      parse_err <= 1'b0;
      if (move_valid && move_ready) begin
        move_valid <= 1'b0;
      end

      if (timed_out) begin
        state     <= S_COL;
        parse_err <= 1'b1;
      end else if (state == S_TILE) begin
        // Commit cycle: any byte landing here is discarded
        state <= S_COL;
        if (rx_valid) parse_err <= 1'b1;
      end else if (rx_valid) begin
        case (state)
          S_COL: begin
            if (is_col(rx_data)) begin
              col_lat <= col_val;
              row_acc <= '0;
              dig_cnt <= 2'd0;
              state   <= S_ROW0;
            end else if (!is_ws(rx_data)) begin
              parse_err <= 1'b1;
            end
          end
          S_ROW0: begin
            if (is_digit(rx_data)) begin
              row_acc <= digit_val;
              dig_cnt <= 2'd1;
              state   <= S_ROW;
            end else begin
              parse_err <= 1'b1;
              state     <= S_COL;
            end
          end
          S_ROW: begin
            if (is_digit(rx_data) && (dig_cnt != 2'd3)) begin
              row_acc <= row_next;
              dig_cnt <= dig_cnt + 2'd1;
            end else if (is_tile(rx_data)) begin
              state <= S_TILE;
              // A held, unaccepted move is never overwritten
              if (out_blocked) begin
                parse_err <= 1'b1;
              end else begin
                move_out   <= {tile_code(rx_data), row_acc, col_lat};
                move_valid <= 1'b1;
              end
            end else begin
              parse_err <= 1'b1;
              state     <= S_COL;
            end
          end
          default: state <= S_COL;
        endcase
      end
    end
  end

endmodule

// File: doc/trax_move_parser.md
TRAX_MOVE_PARSER -- requirements
Module: trax_move_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd1000000, the inter-byte idle limit in clock cycles used when TRAX_PARSER_TIMEOUT_EN is defined.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rx_data  input  8  ASCII byte from the UART receiver.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe marking rx_data valid; cannot be stalled.
REQ-006 SHALL have port move_out  output  22  parsed move: [21:20] tile code, [19:10] row, [9:0] column.
REQ-007 SHALL have port move_valid  output  1  move_out holds an unconsumed move.
REQ-008 SHALL have port move_ready  input  1  consumer accepts move_out when high with move_valid.
REQ-009 SHALL have port parse_err  output  1  one-cycle pulse on any rejected byte, overflow or timeout.

Function
REQ-010 SHALL parse Trax notation <column><row><tile>: column '@'=0, 'A'..'Z'=1..26; row 1-3 decimal digits; tile '+'=2'd0, '/'=2'd1, '\'=2'd2.
REQ-011 SHALL implement states S_COL, S_ROW0, S_ROW, S_TILE; reset state S_COL.
REQ-012 S_COL: column char -> latch column, row accumulator=0, digit count=0, go S_ROW0; space, CR (0x0D), LF (0x0A) ignored; any other byte -> parse_err, stay S_COL.
REQ-013 S_ROW0: digit -> row=digit, count=1, go S_ROW; any other byte -> parse_err, go S_COL.
REQ-014 S_ROW: digit with count<3 -> row=row*10+digit (10-bit result, max 999), count+1; tile char -> complete move, go S_COL; 4th digit or other byte -> parse_err, go S_COL.
REQ-015 S_TILE is reserved for the cycle a completed move is committed; it SHALL return to S_COL the next cycle and discard any rx_valid byte arriving in that cycle with parse_err.
REQ-016 Completed move SHALL load move_out and set move_valid one cycle after the tile byte's rx_valid.
REQ-017 move_valid SHALL stay high and move_out stable until the cycle move_ready is sampled high, then clear the next cycle.
REQ-018 Parsing SHALL continue while move_valid is high; a move completing while move_valid is high and move_ready low SHALL be dropped with parse_err (no overwrite).
REQ-019 Completion and acceptance in the same cycle SHALL load the new move and keep move_valid high.
REQ-020 Bytes with rx_valid low SHALL be ignored; rx_data is sampled only on rx_valid.

Reset
REQ-021 Reset low SHALL immediately force S_COL, move_out=22'd0, move_valid=0, parse_err=0, accumulators and timeout counter to 0.
REQ-022 Reset asserted mid-move SHALL discard the partial move; no move is emitted after release until a full new move arrives.

Configuration
REQ-023 With TRAX_PARSER_TIMEOUT_EN defined, a counter SHALL clear on every rx_valid and, in any state other than S_COL, reaching TIMEOUT_CYCLES SHALL pulse parse_err and return to S_COL.
REQ-024 Without TRAX_PARSER_TIMEOUT_EN, no counter SHALL exist and a partial move SHALL wait indefinitely; TIMEOUT_CYCLES is then unused.

Structure
REQ-025 Shared package trax_pkg SHALL hold tile codes (TILE_PLUS=0, TILE_SLASH=1, TILE_BSLASH=2), move field positions, move width 22, and ASCII constants.
REQ-026 The parser SHALL be a single module with no sub-modules; the output holding register stays inline.

Verification
REQ-027 Bytes "A1+" -> move_out=22'h0_0401 (tile 0, row 1, col 1), move_valid one cycle after '+'.
REQ-028 Bytes "@12\" with move_ready low 5 cycles then high -> move_out={2'd2,10'd12,10'd0} held stable 5 cycles, valid clears after acceptance.
REQ-029 Bytes "B1234/" -> parse_err on '4', no move; then "C3/" -> move {2'd1,10'd3,10'd3}.
REQ-030 "A1+" unaccepted, then "B2/" -> parse_err on '/', move_out stays the A1+ move.
REQ-031 Reset pulsed low after "Z9" -> all outputs zero; subsequent "+" -> parse_err, no move.
REQ-032 TRAX_PARSER_TIMEOUT_EN, TIMEOUT_CYCLES=100: "A" then 100 idle cycles -> parse_err; then "1+" -> parse_err on '1', no move.
